// File: rtl/alu_operand_stage.sv
// Execute-stage operand register feeding the adder/subtractor: forms a/b/c from the
// issued operands and buffers them in a two-entry (main + skid) elastic buffer.
module alu_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_sel_a,
  input  logic            in_sel_b,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic            out_c
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state, state_next;
  logic            accept, consume;
  logic            load_main, main_from_skid, load_skid;
  logic [XLEN-1:0] new_a, new_b;
  logic            new_c;
  logic [XLEN-1:0] main_a, main_b, skid_a, skid_b;
  logic            main_c, skid_c;

  // Handshake flags come from registered state only, so no combinational in->out path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  // A flush cycle neither accepts nor consumes, whatever the handshakes say.
  assign accept  = in_valid & in_ready & ~flush;
  assign consume = out_valid & out_ready & ~flush;

  // Immediate subtract does not exist, so c is forced low whenever b takes the immediate.
  assign new_a = in_sel_a ? in_pc  : in_rs1;
  assign new_b = in_sel_b ? in_imm : in_rs2;
  assign new_c = in_sub & ~in_sel_b;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_next     = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // NOTE: the two data entries are reset too, because outputs must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_a <= '0;
      main_b <= '0;
      main_c <= 1'b0;
    end else if (load_main) begin
      main_a <= new_a;
      main_b <= new_b;
      main_c <= new_c;
    end else if (main_from_skid) begin
      main_a <= skid_a;
      main_b <= skid_b;
      main_c <= skid_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_a <= '0;
      skid_b <= '0;
      skid_c <= 1'b0;
    end else if (load_skid) begin
      skid_a <= new_a;
      skid_b <= new_b;
      skid_c <= new_c;
    end
  end

  // Main entry drives the adder directly; it is untouched while stalled or empty.
  assign out_a = main_a;
  assign out_b = main_b;
  assign out_c = main_c;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: the driver queues expected {c,b,a} on each accept,
// a negedge monitor pops and compares on every consume and checks output hold under stall.
module tb_alu_operand_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, in_sel_a, in_sel_b, in_sub;
  logic [XLEN-1:0] in_rs1, in_rs2, in_imm, in_pc;
  logic            out_valid, out_ready, out_c;
  logic [XLEN-1:0] out_a, out_b;

  int total = 0;
  int bad   = 0;

  logic [64:0] sb_q[$];
  logic [64:0] held;
  logic        stall_prev = 1'b0;
  logic        done;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .in_sel_a(in_sel_a), .in_sel_b(in_sel_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c)
  );

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Call just after a rising edge; returns just after the edge that took the entry.
  task automatic send(input logic [31:0] rs1, rs2, imm, pc, input logic sa, sb, sub,
                      input logic [31:0] ea, eb, input logic ec);
    int waited = 0;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
    in_sel_a = sa; in_sel_b = sb; in_sub = sub;
    forever begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sb_q.push_back({ec, eb, ea});
        break;
      end
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 96'(waited), 96'(0));
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (stall_prev) begin
        check("stall_valid", 96'(out_valid), 96'(1));
        check("stall_hold", 96'({out_c, out_b, out_a}), 96'(held));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("unexpected_out", 96'({out_c, out_b, out_a}), 96'(0));
        else                  check("out_data", 96'({out_c, out_b, out_a}), 96'(sb_q.pop_front()));
      end
    end
    stall_prev = !rst && !flush && out_valid && !out_ready;
    held       = {out_c, out_b, out_a};
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0;
    in_sel_a = 1'b0; in_sel_b = 1'b0; in_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 96'(out_valid), 96'(0));
    check("rst_in_ready", 96'(in_ready), 96'(1));
    check("rst_out_abc", 96'({out_c, out_b, out_a}), 96'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic register-register subtract, one-cycle latency.
    out_ready = 1'b1;
    send(32'd5, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd3, 1'b1);
    check("lat_out_valid", 96'(out_valid), 96'(1));
    check("lat_out_abc", 96'({out_c, out_b, out_a}), 96'({1'b1, 32'd3, 32'd5}));

    // pc + imm, subtract request ignored for immediates.
    send(32'd7, 32'd9, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFC, 1'b0);
    check("imm_out_abc", 96'({out_c, out_b, out_a}), 96'({1'b0, 32'hFFFF_FFFC, 32'h100}));
    send(32'h11, 32'h22, 32'h33, 32'h44, 1'b1, 1'b0, 1'b1, 32'h44, 32'h22, 1'b1);
    send(32'h55, 32'h66, 32'h77, 32'h88, 1'b0, 1'b1, 1'b0, 32'h55, 32'h77, 1'b0);

    // Fill to FULL under stall, then drain in order.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'hA1, 32'hA2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hA1, 32'hA2, 1'b0);
    send(32'hB1, 32'hB2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hB1, 32'hB2, 1'b1);
    check("full_in_ready", 96'(in_ready), 96'(0));
    check("full_head_a", 96'(out_a), 96'(32'hA1));
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_second_a", 96'(out_a), 96'(32'hB1));
    @(posedge clk); #1;
    check("drain_empty", 96'(out_valid), 96'(0));
    check("drain_sb_empty", 96'(sb_q.size()), 96'(0));

    // Back-to-back stream: in_ready must never drop.
    for (int i = 0; i < 16; i++) begin
      check("stream_in_ready", 96'(in_ready), 96'(1));
      send(32'(i), 32'(100 + i), 32'h0, 32'h0, 1'b0, 1'b0, i[0], 32'(i), 32'(100 + i), i[0]);
    end
    @(posedge clk); #1;
    check("stream_sb_empty", 96'(sb_q.size()), 96'(0));

    // Flush while ONE with in_valid high: nothing accepted.
    out_ready = 1'b0;
    send(32'hC1, 32'hC2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC1, 32'hC2, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_rs1 = 32'hD1; in_rs2 = 32'hD2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    check("flush1_out_valid", 96'(out_valid), 96'(0));
    check("flush1_in_ready", 96'(in_ready), 96'(1));

    // Flush while FULL with in_valid high.
    send(32'hE1, 32'hE2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hE1, 32'hE2, 1'b0);
    send(32'hF1, 32'hF2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hF1, 32'hF2, 1'b0);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    check("flush2_out_valid", 96'(out_valid), 96'(0));
    check("flush2_in_ready", 96'(in_ready), 96'(1));
    repeat (3) @(posedge clk);
    #1;
    check("flush2_stays_empty", 96'(out_valid), 96'(0));

    // Asynchronous reset while FULL and stalled.
    out_ready = 1'b0;
    send(32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h5678, 1'b1);
    send(32'h9ABC, 32'hDEF0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h9ABC, 32'hDEF0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 96'(out_valid), 96'(0));
    check("arst_in_ready", 96'(in_ready), 96'(1));
    check("arst_out_abc", 96'({out_c, out_b, out_a}), 96'(0));
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Random valid/ready traffic against the scoreboard.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2500; i++) begin
          logic [31:0] r1, r2, im, p;
          logic        sa, sb, su;
          r1 = $urandom; r2 = $urandom; im = $urandom; p = $urandom;
          sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1)); su = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send(r1, r2, im, p, sa, sb, su, sa ? p : r1, sb ? im : r2, su & ~sb);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("random_sb_empty", 96'(sb_q.size()), 96'(0));
    check("random_final_empty", 96'(out_valid), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
